pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_pkg.sv | 7 +
 rtl/pwm_meas.sv | 103 ++++++++++
 rtl/pwm_capture.sv | 60 ++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared channel state type and default timing parameters for PWM capture/generation.
package pwm_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
    localparam int unsigned N_DEF   = 50;
    localparam int unsigned NW_DEF  = 6;
    localparam int unsigned NUM_DEF = 999_999_999;
endpackage

// File: rtl/pwm_meas.sv
// pwm_meas: one capture channel -- synchronizer, edge detect, IDLE/HIGH/LOW FSM,
// tick counters and published high-time/period registers.
module pwm_meas
    import pwm_pkg::*;
#(
    parameter logic [31:0] NUM = NUM_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic        tick_i,
    input  logic        x_i,
    output logic [31:0] h_o,
    output logic [31:0] p_o,
    output logic        vld_o,
    output logic        to_o
);
    // sync_q = {delay, sync2, sync1}
    logic [2:0]  sync_q;
    state_e      state_q, state_d;
    logic [31:0] hc_q, hc_d, pc_q, pc_d, pend_q, pend_d, h_q, h_d, p_q, p_d;
    logic        vld_q, vld_d, to_q, to_d;
    logic        rise, fall;
    logic [31:0] inc;
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];
    assign inc  = {31'b0, tick_i};
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= IDLE;
            hc_q    <= '0;
            pc_q    <= '0;
            pend_q  <= '0;
            h_q     <= '0;
            p_q     <= '0;
            vld_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], x_i};
            state_q <= state_d;
            hc_q    <= hc_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            h_q     <= h_d;
            p_q     <= p_d;
            vld_q   <= vld_d;
            to_q    <= to_d;
        end
    end
    // The edge cycle belongs to the new interval, so restarts load the current tick.
    always_comb begin
        state_d = state_q;
        hc_d    = hc_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        h_d     = h_q;
        p_d     = p_q;
        vld_d   = 1'b0;
        to_d    = 1'b0;
        if (!en_i) begin
            state_d = IDLE;
            hc_d    = '0;
            pc_d    = '0;
        end else if (state_q != IDLE && pc_q == NUM) begin
            state_d = IDLE;
            hc_d    = '0;
            pc_d    = '0;
            to_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (rise) begin
                    state_d = HIGH;
                    hc_d    = inc;
                    pc_d    = inc;
                end
                HIGH: begin
                    pc_d = pc_q + inc;
                    hc_d = fall ? hc_q : hc_q + inc;
                    if (fall) begin
                        state_d = LOW;
                        pend_d  = hc_q;
                    end
                end
                LOW: begin
                    pc_d = rise ? inc : pc_q + inc;
                    if (rise) begin
                        state_d = HIGH;
                        hc_d    = inc;
                        h_d     = pend_q;
                        p_d     = pc_q;
                        vld_d   = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    assign h_o   = h_q;
    assign p_o   = p_q;
    assign vld_o = vld_q;
    assign to_o  = to_q;
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: four-channel PWM high-time/period capture sharing one tick prescaler.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned NW  = NW_DEF,
    parameter int unsigned NUM = NUM_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [3:0]  x,
    output logic [31:0] h0,
    output logic [31:0] h1,
    output logic [31:0] h2,
    output logic [31:0] h3,
    output logic [31:0] p0,
    output logic [31:0] p1,
    output logic [31:0] p2,
    output logic [31:0] p3,
    output logic [3:0]  vld,
    output logic [3:0]  to
);
    logic [NW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;
    logic [31:0]   h_w [4];
    logic [31:0]   p_w [4];
    assign tick_d = cnt_q == NW'(N - 1);
    assign cnt_d  = tick_d ? '0 : cnt_q + NW'(1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_ch
        pwm_meas #(.NUM(32'(NUM))) u_meas (
            .clk_i (clk),
            .rst_ni(reset_n),
            .en_i  (en),
            .tick_i(tick_q),
            .x_i   (x[i]),
            .h_o   (h_w[i]),
            .p_o   (p_w[i]),
            .vld_o (vld[i]),
            .to_o  (to[i])
        );
    end
    assign h0 = h_w[0];
    assign h1 = h_w[1];
    assign h2 = h_w[2];
    assign h3 = h_w[3];
    assign p0 = p_w[0];
    assign p1 = p_w[1];
    assign p2 = p_w[2];
    assign p3 = p_w[3];
endmodule
